// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, controller state encoding and default divide-by-zero result
package alu_pkg;
   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_SUB   = 3'd1;
   localparam logic [2:0] OP_MUL   = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_AND   = 3'd4;
   localparam logic [2:0] OP_OR    = 3'd5;
   localparam logic [2:0] OP_XOR   = 3'd6;
   localparam logic [2:0] OP_LOADI = 3'd7;
   localparam logic [7:0] DIV0_DEFAULT = 8'hFF;
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 8-bit register file, one sync write port, three combinational read ports
module alu_regfile
   import alu_pkg::*;
#(
   parameter int NREGS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [1:0] wa,
   input  logic [7:0] wd,
   input  logic [1:0] ra,
   input  logic [1:0] rb,
   input  logic [1:0] rdbg,
   output logic [7:0] da,
   output logic [7:0] db,
   output logic [7:0] ddbg
);
   logic [7:0] mem [NREGS];
   assign da   = mem[ra];
   assign db   = mem[rb];
   assign ddbg = mem[rdbg];
   // reset clears every entry; otherwise a single write per cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      end else if (we) begin
         mem[wa] <= wd;
      end
   end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues register-to-register commands to an external ALU and writes results back
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int         NREGS      = 4,
   parameter logic [7:0] DIV0_VALUE = DIV0_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [1:0] cmd_dst,
   input  logic [1:0] cmd_src_a,
   input  logic [1:0] cmd_src_b,
   input  logic [7:0] cmd_imm,
   output logic [7:0] alu_operand1,
   output logic [7:0] alu_operand2,
   output logic [2:0] alu_operation,
   output logic       alu_enable,
   input  logic [7:0] alu_result,
   output logic       wb_valid,
   output logic [1:0] wb_dst,
   output logic [7:0] wb_data,
   output logic       err_div0,
   output logic       busy,
   input  logic [1:0] dbg_addr,
   output logic [7:0] dbg_data
);
   state_t     state, state_n;
   logic [2:0] op_q;
   logic [1:0] dst_q;
   logic [7:0] res_q, rd_a, rd_b;
   logic       accept, div0;
   assign cmd_ready  = state == S_IDLE;
   assign busy       = !cmd_ready;
   assign accept     = cmd_valid && cmd_ready;
   assign div0       = alu_operation == OP_DIV && alu_operand2 == 8'd0;
   assign alu_enable = state == S_EXEC && !div0;
   assign wb_valid   = state == S_WB;
   assign wb_dst     = dst_q;
   assign wb_data    = res_q;
   assign err_div0   = wb_valid && op_q == OP_DIV && alu_operand2 == 8'd0;
   alu_regfile #(.NREGS(NREGS)) u_rf (
      .clk(clk), .rst(rst), .we(wb_valid), .wa(dst_q), .wd(res_q),
      .ra(cmd_src_a), .rb(cmd_src_b), .rdbg(dbg_addr),
      .da(rd_a), .db(rd_b), .ddbg(dbg_data)
   );
   // state register
   always_ff @(posedge clk) state <= rst ? S_IDLE : state_n;
   // LOADI skips EXEC; every other op spends one cycle at the ALU
   always_comb begin
      state_n = state;
      state_n = state == S_IDLE ? (accept ? (cmd_op == OP_LOADI ? S_WB : S_EXEC) : S_IDLE) :
                state == S_EXEC ? S_WB : S_IDLE;
   end
   // operands are sampled at accept so aliased dst/src is safe; ALU inputs only move for ALU ops
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q          <= '0;
         dst_q         <= '0;
         res_q         <= '0;
         alu_operand1  <= '0;
         alu_operand2  <= '0;
         alu_operation <= '0;
      end else begin
         if (accept) begin
            op_q  <= cmd_op;
            dst_q <= cmd_dst;
            if (cmd_op == OP_LOADI) begin
               res_q <= cmd_imm;
            end else begin
               alu_operand1  <= rd_a;
               alu_operand2  <= rd_b;
               alu_operation <= cmd_op;
            end
         end
         if (state == S_EXEC) res_q <= div0 ? DIV0_VALUE : alu_result;
      end
   end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;
   import alu_pkg::*;
   logic       clk = 0, rst = 1;
   logic       cmd_valid = 0, cmd_ready;
   logic [2:0] cmd_op = 0;
   logic [1:0] cmd_dst = 0, cmd_src_a = 0, cmd_src_b = 0, dbg_addr = 0, wb_dst;
   logic [7:0] cmd_imm = 0, alu_operand1, alu_operand2, alu_result, wb_data, dbg_data;
   logic [2:0] alu_operation;
   logic       alu_enable, wb_valid, err_div0, busy;
   int         total = 0, bad = 0;
   logic [10:0] q[$];

   alu_issue_ctrl dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_imm(cmd_imm),
      .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_operation(alu_operation),
      .alu_enable(alu_enable), .alu_result(alu_result), .wb_valid(wb_valid), .wb_dst(wb_dst),
      .wb_data(wb_data), .err_div0(err_div0), .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   // external ALU model; divide by zero returns junk the controller must not write
   always_comb begin
      case (alu_operation)
         OP_ADD:  alu_result = alu_operand1 + alu_operand2;
         OP_SUB:  alu_result = alu_operand1 - alu_operand2;
         OP_MUL:  alu_result = alu_operand1 * alu_operand2;
         OP_DIV:  alu_result = alu_operand2 == 0 ? 8'hAA : alu_operand1 / alu_operand2;
         OP_AND:  alu_result = alu_operand1 & alu_operand2;
         OP_OR:   alu_result = alu_operand1 | alu_operand2;
         OP_XOR:  alu_result = alu_operand1 ^ alu_operand2;
         default: alu_result = 8'h00;
      endcase
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   // monitor: every write-back pops one expectation {err, dst, data}
   always @(negedge clk) begin
      if (!rst && wb_valid) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL wb_unexpected got=%h/%h want=none", wb_dst, wb_data);
         end else begin
            automatic logic [10:0] e = q.pop_front();
            if ({err_div0, wb_dst, wb_data} !== e) begin
               bad++;
               $display("FAIL wb got err=%b dst=%0d data=%h want err=%b dst=%0d data=%h",
                        err_div0, wb_dst, wb_data, e[10], e[9:8], e[7:0]);
            end
         end
      end
   end

   task automatic dbg(input logic [1:0] a, input logic [7:0] exp);
      dbg_addr = a;
      #1 chk($sformatf("dbg_r%0d", a), dbg_data, exp);
   endtask

   task automatic issue(input logic [2:0] op, input logic [1:0] d, input logic [1:0] a,
                        input logic [1:0] b, input logic [7:0] imm, input logic [7:0] exp,
                        input logic e);
      int n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", cmd_ready, 8'd1);
      cmd_valid = 1; cmd_op = op; cmd_dst = d; cmd_src_a = a; cmd_src_b = b; cmd_imm = imm;
      q.push_back({e, d, exp});
      @(posedge clk);
      #1 cmd_valid = 0;
      cmd_src_a = ~a; cmd_src_b = ~b; cmd_imm = ~imm;
      @(negedge clk);
      chk("en_c1", alu_enable, op != OP_LOADI && !e);
      chk("wb_c1", wb_valid, op == OP_LOADI);
      chk("busy_c1", busy, 8'd1);
      if (op != OP_LOADI) begin
         @(negedge clk);
         chk("en_c2", alu_enable, 8'd0);
         chk("wb_c2", wb_valid, 8'd1);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_ready", cmd_ready, 8'd1);
      chk("rst_busy", busy, 8'd0);
      chk("rst_en", alu_enable, 8'd0);
      chk("rst_wb", wb_valid, 8'd0);
      chk("rst_err", err_div0, 8'd0);
      chk("rst_op1", alu_operand1, 8'd0);
      chk("rst_wbd", wb_data, 8'd0);
      for (int i = 0; i < 4; i++) dbg(i[1:0], 8'h00);
      issue(OP_LOADI, 0, 0, 0, 8'h05, 8'h05, 0);
      issue(OP_LOADI, 1, 0, 0, 8'h03, 8'h03, 0);
      @(negedge clk);
      dbg(0, 8'h05);
      dbg(1, 8'h03);
      issue(OP_ADD,   2, 0, 1, 8'h00, 8'h08, 0);
      issue(OP_SUB,   3, 1, 0, 8'h00, 8'hFE, 0);
      issue(OP_LOADI, 2, 0, 0, 8'hF0, 8'hF0, 0);
      issue(OP_LOADI, 3, 0, 0, 8'h20, 8'h20, 0);
      issue(OP_ADD,   1, 2, 3, 8'h00, 8'h10, 0);
      issue(OP_LOADI, 2, 0, 0, 8'h10, 8'h10, 0);
      issue(OP_MUL,   1, 2, 3, 8'h00, 8'h00, 0);
      issue(OP_XOR,   0, 0, 0, 8'h00, 8'h00, 0);
      issue(OP_LOADI, 1, 0, 0, 8'h07, 8'h07, 0);
      issue(OP_DIV,   2, 1, 0, 8'h00, 8'hFF, 1);
      issue(OP_LOADI, 3, 0, 0, 8'h02, 8'h02, 0);
      issue(OP_DIV,   2, 1, 3, 8'h00, 8'h03, 0);
      issue(OP_OR,    0, 1, 3, 8'h00, 8'h07, 0);
      issue(OP_AND,   0, 1, 3, 8'h00, 8'h02, 0);
      // back-to-back with cmd_valid held high: second op must see the first's result
      @(negedge clk);
      chk("b2b_ready0", cmd_ready, 8'd1);
      cmd_valid = 1; cmd_op = OP_ADD; cmd_dst = 2; cmd_src_a = 1; cmd_src_b = 3;
      q.push_back({1'b0, 2'd2, 8'h09});
      @(posedge clk);
      #1 cmd_dst = 3; cmd_src_a = 2; cmd_src_b = 2;
      q.push_back({1'b0, 2'd3, 8'h12});
      @(negedge clk);
      chk("b2b_ready1", cmd_ready, 8'd0);
      @(negedge clk);
      chk("b2b_ready2", cmd_ready, 8'd0);
      @(negedge clk);
      chk("b2b_ready3", cmd_ready, 8'd1);
      @(posedge clk);
      #1 cmd_valid = 0;
      repeat (3) @(negedge clk);
      dbg(3, 8'h12);
      // reset during EXEC aborts the write
      @(negedge clk);
      cmd_valid = 1; cmd_op = OP_ADD; cmd_dst = 0; cmd_src_a = 1; cmd_src_b = 1;
      @(posedge clk);
      #1 cmd_valid = 0;
      @(negedge clk);
      chk("abort_en", alu_enable, 8'd1);
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("abort_wb", wb_valid, 8'd0);
      chk("abort_ready", cmd_ready, 8'd1);
      chk("abort_busy", busy, 8'd0);
      chk("abort_wbd", wb_data, 8'd0);
      for (int i = 0; i < 4; i++) dbg(i[1:0], 8'h00);
      issue(OP_LOADI, 1, 0, 0, 8'h42, 8'h42, 0);
      @(negedge clk);
      dbg(1, 8'h42);
      chk("drain", q.size(), 8'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencing front end for the 8-bit combinational ALU: accepts register-to-register commands over a valid/ready handshake, reads operands from a private 4×8 register file, drives the ALU's operand/operation/enable inputs, captures the result and writes it back. It is the initiator side of the ALU interface and sits between the instruction decoder and the ALU.

## Interface
Parameters:
- NREGS, 4, number of 8-bit registers (fixed at 4; address width 2)
- DIV0_VALUE, 8'hFF, result written back for divide by zero

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 LOADI
- cmd_dst  in  2  destination register
- cmd_src_a  in  2  operand1 register
- cmd_src_b  in  2  operand2 register
- cmd_imm  in  8  immediate for LOADI
- alu_operand1  out  8  to ALU
- alu_operand2  out  8  to ALU
- alu_operation  out  3  to ALU
- alu_enable  out  1  to ALU
- alu_result  in  8  from ALU
- wb_valid  out  1  one-cycle pulse: register written this cycle
- wb_dst  out  2  register being written
- wb_data  out  8  value being written
- err_div0  out  1  one-cycle pulse coincident with wb_valid for DIV with operand2 == 0
- busy  out  1  high whenever state ≠ IDLE
- dbg_addr  in  2  debug read address
- dbg_data  out  8  combinational read of register dbg_addr

## Operation
- States: IDLE, EXEC, WB. cmd_ready = 1 only in IDLE.
- IDLE: on cmd_valid & cmd_ready latch op, dst, regfile[src_a], regfile[src_b] (or imm). LOADI → WB; all other ops → EXEC.
- EXEC: alu_enable = 1; alu_operand1/2/operation driven from latched values; alu_result captured into result register at end of cycle → WB.
- DIV with latched operand2 == 0: EXEC still entered but alu_enable = 0; result register loaded with DIV0_VALUE; err_div0 raised in WB.
- WB: wb_valid = 1, wb_dst/wb_data driven from registers; regfile[dst] written at end of cycle → IDLE.
- alu_enable is 0 in IDLE and WB; alu_operand1/2/operation hold last values when not enabled.
- Arithmetic is the ALU's: 8-bit wrap on ADD/SUB, MUL truncated to low 8 bits, DIV unsigned quotient. Controller adds no widening.
- src_a, src_b, dst may alias; operands are sampled at accept, so dst == src is safe.
- cmd_valid while not ready is ignored; command fields need only be stable in the accept cycle.

## Timing
- Reset: state IDLE, all regs 0, cmd_ready 1, busy/alu_enable/wb_valid/err_div0 0, alu_operand1/2/operation/wb_dst/wb_data 0. Reset mid-operation aborts: no wb_valid, no write.
- ALU op: accept cycle 0, EXEC cycle 1, WB cycle 2, cmd_ready again cycle 3. Throughput 1 op / 3 cycles.
- LOADI: accept cycle 0, WB cycle 1, ready cycle 2.
- Read-after-write: command accepted the cycle after WB sees the new value. dbg_data shows it from the cycle after WB.

## Structure
- alu_pkg: opcode localparams (OP_ADD … OP_LOADI), state encoding, DIV0_VALUE default.
- Sub-module alu_regfile: 4×8, one sync write port, three combinational read ports (a, b, dbg), reset clears all entries.
- FSM and capture registers in alu_issue_ctrl; ALU itself instantiated outside.

## Test plan
- Reset, then LOADI r0=0x05, LOADI r1=0x03 → wb_valid at cycle 1 each, dbg r0 = 0x05, r1 = 0x03.
- ADD r2=r0+r1 → alu_enable high exactly cycle 1, wb_data 0x08 at cycle 2; ADD 0xF0+0x20 → 0x10.
- MUL 0x10×0x20 → 0x00; SUB 0x03−0x05 → 0xFE; XOR r0=r0^r0 → 0x00 (aliasing).
- DIV 0x07/0x00 → alu_enable stays 0, wb_data 0xFF, err_div0 pulses with wb_valid; DIV 0x07/0x02 → 0x03.
- Back-to-back cmd_valid held high: accepts only in IDLE, second op reads first op's result.
- Assert rst during EXEC → no wb_valid, all registers read 0, cmd_ready 1 next cycle.
